// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and sizing constants for the broadcast side of the common data bus.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package cdb_arbiter_pkg;

    localparam int NUM_CDB_ENTRIES   = 2;
    localparam int RO_BUFFER_ENTRIES = 8;
    localparam int CDB_NUM_SRC       = 4;
    localparam int CDB_FIFO_DEPTH    = 2;
    localparam int TAG_W             = $clog2(RO_BUFFER_ENTRIES);
    localparam int DATA_W            = 32;

    typedef logic [DATA_W-1:0] rv32i_word;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        rv32i_word        value;
    } cdb_entry_t;

    typedef cdb_entry_t [NUM_CDB_ENTRIES-1:0] cdb_t;

    // Increment modulo n; used for the round-robin pointer.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO: circular buffer of {tag, value} with wrapping pointers.
// Latency: a push at edge N is visible at the head after edge N (one-cycle write-to-read).
// Backpressure: o_full is derived from the registered count only; pushes while full are ignored.
module cdb_src_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [TAG_W-1:0] i_tag,
    input  rv32i_word        i_value,
    output logic             o_full,
    output logic             o_empty,
    output logic [TAG_W-1:0] o_head_tag,
    output rv32i_word        o_head_value
);

    localparam int AW = $clog2(DEPTH);

    logic [TAG_W-1:0] r_tag [DEPTH];
    rv32i_word        r_val [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full       = (r_count == (AW+1)'(DEPTH));
    assign o_empty      = (r_count == '0);
    assign w_do_push    = i_push & ~o_full;
    assign w_do_pop     = i_pop & ~o_empty;
    assign o_head_tag   = r_tag[r_rptr];
    assign o_head_value = r_val[r_rptr];

    // Pointer and occupancy tracking; reset and flush both empty the buffer.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; a push coincident with flush or reset is discarded.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush && !rst) begin
            r_tag[r_wptr] <= i_tag;
            r_val[r_wptr] <= i_value;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus transmitter: buffers unit results per source, round-robin picks up to NUM_CDB heads.
// Latency: result accepted at edge N is broadcast (registered) after edge N+1 at the earliest.
// Backpressure: src_ready[s] deasserts while FIFO s is full, from registered count only.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC    = CDB_NUM_SRC,
    parameter int FIFO_DEPTH = CDB_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
    input  logic [NUM_SRC*DATA_W-1:0] src_value,
    output logic [NUM_SRC-1:0]        src_ready,
    output cdb_t                      cdb_o
);

    localparam int NUM_CDB = NUM_CDB_ENTRIES;
    localparam int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int LANE_W  = (NUM_CDB > 1) ? $clog2(NUM_CDB) : 1;

    logic [NUM_SRC-1:0] w_full;
    logic [NUM_SRC-1:0] w_empty;
    logic [NUM_SRC-1:0] w_push;
    logic [NUM_SRC-1:0] w_grant;
    logic [TAG_W-1:0]   w_head_tag [NUM_SRC];
    rv32i_word          w_head_val [NUM_SRC];
    logic [NUM_CDB-1:0] w_lane_vld;
    logic [SRC_W-1:0]   w_lane_src [NUM_CDB];
    logic [SRC_W-1:0]   w_rr_nxt;
    logic               w_any_grant;
    logic [SRC_W-1:0]   r_rr_ptr;
    cdb_t               r_cdb;

    assign src_ready = ~w_full;
    assign w_push    = src_valid & ~w_full;
    assign cdb_o     = r_cdb;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        cdb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk          (clk),
            .rst          (rst),
            .i_flush      (flush),
            .i_push       (w_push[s]),
            .i_pop        (w_grant[s]),
            .i_tag        (src_tag[s*TAG_W +: TAG_W]),
            .i_value      (src_value[s*DATA_W +: DATA_W]),
            .o_full       (w_full[s]),
            .o_empty      (w_empty[s]),
            .o_head_tag   (w_head_tag[s]),
            .o_head_value (w_head_val[s])
        );
    end

    // Scan non-empty FIFOs from rr_ptr upward; the k-th hit is packed into lane k.
    always_comb begin
        int n;
        int idx;
        int last;
        w_grant    = '0;
        w_lane_vld = '0;
        for (int k = 0; k < NUM_CDB; k++) w_lane_src[k] = '0;
        n    = 0;
        last = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = int'(r_rr_ptr) + i;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (!w_empty[SRC_W'(idx)] && n < NUM_CDB) begin
                w_grant[SRC_W'(idx)]    = 1'b1;
                w_lane_vld[LANE_W'(n)]  = 1'b1;
                w_lane_src[LANE_W'(n)]  = SRC_W'(idx);
                n    = n + 1;
                last = idx;
            end
        end
        w_any_grant = (n != 0);
        w_rr_nxt    = SRC_W'(wrap_inc(last, NUM_SRC));
    end

    // Round-robin pointer moves just past the last source served this cycle.
    always_ff @(posedge clk) begin
        if (rst || flush)     r_rr_ptr <= '0;
        else if (w_any_grant) r_rr_ptr <= w_rr_nxt;
    end

    for (genvar k = 0; k < NUM_CDB; k++) begin : g_lane
        // Register the granted head into its lane; idle lanes carry the all-zero encoding.
        always_ff @(posedge clk) begin
            if (rst || flush || !w_lane_vld[k]) begin
                r_cdb[k] <= '0;
            end else begin
                r_cdb[k] <= {1'b1, w_head_tag[w_lane_src[k]], w_head_val[w_lane_src[k]]};
            end
        end
    end

endmodule
